// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement A - B, LSB first.
// One full-subtractor cell plus a borrow flip-flop, unrolled in time.
// A request is taken in IDLE or DONE. WIDTH RUN cycles then process one bit
// each. The result and flags are loaded on the edge that enters DONE and are
// held until the next completion.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Full-subtractor cell: returns {borrow_next, difference_bit}
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic w);
    logic d_bit;
    logic bw;
    d_bit = x ^ y ^ w;
    bw    = (~x & y) | (~x & w) | (y & w);
    return {bw, d_bit};
  endfunction

  // Signed overflow: operand signs differ and the result sign differs from A
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_a_q, sr_a_d;
  logic [WIDTH-1:0] sr_b_q, sr_b_d;
  logic [WIDTH-1:0] sr_r_q, sr_r_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    count_q, count_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [1:0]       cell_s;
  logic [WIDTH-1:0] result_s;

  assign cell_s   = full_sub(sr_a_q[0], sr_b_q[0], borrow_q);
  assign result_s = {cell_s[0], sr_r_q[WIDTH-1:1]};

  // Next-state, datapath and output-flag logic
  always_comb begin
    state_d      = state_q;
    sr_a_d       = sr_a_q;
    sr_b_d       = sr_b_q;
    sr_r_d       = sr_r_q;
    borrow_d     = borrow_q;
    count_d      = count_q;
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    zero_d       = zero_q;
    ovf_d        = ovf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          sr_a_d   = a;
          sr_b_d   = b;
          sr_r_d   = {WIDTH{1'b0}};
          borrow_d = 1'b0;
          count_d  = {CW{1'b0}};
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        sr_r_d   = result_s;
        sr_a_d   = {1'b0, sr_a_q[WIDTH-1:1]};
        sr_b_d   = {1'b0, sr_b_q[WIDTH-1:1]};
        borrow_d = cell_s[1];
        count_d  = count_q + {{(CW-1){1'b0}}, 1'b1};
        if (count_q == LAST_BIT) begin
          // The last bit is processed this cycle, so publish the complete result.
          diff_d       = result_s;
          borrow_out_d = cell_s[1];
          zero_d       = (result_s == {WIDTH{1'b0}});
          ovf_d        = sub_ovf(a_msb_q, b_msb_q, result_s[WIDTH-1]);
          state_d      = ST_DONE;
        end else begin
          state_d      = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and registered outputs; async reset aborts any operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sr_a_q       <= {WIDTH{1'b0}};
      sr_b_q       <= {WIDTH{1'b0}};
      sr_r_q       <= {WIDTH{1'b0}};
      borrow_q     <= 1'b0;
      count_q      <= {CW{1'b0}};
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      diff_q       <= {WIDTH{1'b0}};
      borrow_out_q <= 1'b0;
      zero_q       <= 1'b0;
      ovf_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_a_q       <= sr_a_d;
      sr_b_q       <= sr_b_d;
      sr_r_q       <= sr_r_d;
      borrow_q     <= borrow_d;
      count_q      <= count_d;
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      zero_q       <= zero_d;
      ovf_q        <= ovf_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign zero       = zero_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 vector table and corner
// sequences, plus an exhaustive sweep on a WIDTH=3 instance.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start8, busy8, done8, borrow8, zero8, ovf8;
  logic [7:0] a8, b8, diff8;
  logic       start3, busy3, done3, borrow3, zero3, ovf3;
  logic [2:0] a3, b3, diff3;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow8),
    .zero(zero8), .ovf(ovf8)
  );

  serial_subtractor #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .diff(diff3), .borrow_out(borrow3),
    .zero(zero3), .ovf(ovf3)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       brw;
    logic       zro;
    logic       ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one request for a single cycle; returns at the negedge after acceptance
  task automatic start_op8(input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    a8 = av;
    b8 = bv;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Count negedges until done is seen, bounded
  task automatic wait_done8(output int cyc);
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int pulses;
    logic [7:0] seen_diff;
    logic [2:0] ea, eb, ed;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'hA5, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 8'h80, 8'h7F, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{8'h01, 8'h80, 8'h81, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    start3 = 1'b0; a3 = 3'd0;  b3 = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_diff", diff8, 8'h00);
    chk("rst_borrow", borrow8, 1'b0);
    chk("rst_zero", zero8, 1'b0);
    chk("rst_ovf", ovf8, 1'b0);
    rst_n = 1'b1;

    // Reset in the middle of an operation aborts it
    start_op8(8'h40, 8'h20);
    chk("abort_busy_before", busy8, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy8, 1'b0);
    chk("abort_done", done8, 1'b0);
    chk("abort_diff", diff8, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8 === 1'b1) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    chk("abort_diff_held", diff8, 8'h00);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      start_op8(vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_busy", i), busy8, 1'b1);
      wait_done8(cyc);
      chk($sformatf("v%0d_latency", i), cyc, 8);
      chk($sformatf("v%0d_diff", i), diff8, vecs[i].diff);
      chk($sformatf("v%0d_borrow", i), borrow8, vecs[i].brw);
      chk($sformatf("v%0d_zero", i), zero8, vecs[i].zro);
      chk($sformatf("v%0d_ovf", i), ovf8, vecs[i].ovf);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), done8, 1'b0);
      chk($sformatf("v%0d_diff_hold", i), diff8, vecs[i].diff);
    end

    // Back-to-back: start accepted in DONE with no idle gap
    start_op8(8'hA5, 8'hA5);
    wait_done8(cyc);
    chk("b2b_first_zero", zero8, 1'b1);
    chk("b2b_first_diff", diff8, 8'h00);
    a8 = 8'h10;
    b8 = 8'h01;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("b2b_busy_no_gap", busy8, 1'b1);
    wait_done8(cyc);
    chk("b2b_latency", cyc, 8);
    chk("b2b_diff", diff8, 8'h0F);
    chk("b2b_zero", zero8, 1'b0);

    // Start during RUN is ignored
    @(negedge clk);
    start_op8(8'h09, 8'h04);
    @(negedge clk);
    a8 = 8'h00;
    b8 = 8'h01;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    pulses = 0;
    seen_diff = 8'hXX;
    repeat (24) begin
      @(negedge clk);
      if (done8 === 1'b1) begin
        pulses++;
        seen_diff = diff8;
      end
    end
    chk("ignore_pulses", pulses, 1);
    chk("ignore_diff", seen_diff, 8'h05);
    chk("ignore_idle", busy8, 1'b0);

    // Exhaustive WIDTH=3 sweep
    for (int ai = 0; ai < 8; ai++) begin
      for (int bi = 0; bi < 8; bi++) begin
        ea = ai[2:0];
        eb = bi[2:0];
        ed = ea - eb;
        @(negedge clk);
        a3 = ea;
        b3 = eb;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        cyc = 0;
        while (done3 !== 1'b1 && cyc < 20) begin
          @(negedge clk);
          cyc++;
        end
        chk($sformatf("w3_%0d_%0d_latency", ai, bi), cyc, 3);
        chk($sformatf("w3_%0d_%0d_diff", ai, bi), diff3, ed);
        chk($sformatf("w3_%0d_%0d_borrow", ai, bi), borrow3, (ai < bi));
        chk($sformatf("w3_%0d_%0d_ovf", ai, bi), ovf3,
            ((ea[2] != eb[2]) && (ed[2] != ea[2])));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
